// File: rtl/axi3_ic_pkg.sv
// Shared definitions for the AXI3 interconnect write path: arbiter FSM
// states, address-region codes, slave-select encodings and BRESP values.
package axi3_ic_pkg;

    // Write-arbiter FSM states (normal path and decode-error path)
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_DATA      = 3'd2,
        ST_RESP      = 3'd3,
        ST_DERR_ADDR = 3'd4,
        ST_DERR_DATA = 3'd5,
        ST_DERR_RESP = 3'd6
    } arb_state_e;

    // AWADDR[31:28] regions that map to a real slave
    localparam logic [3:0] REGION_MEM = 4'h0;
    localparam logic [3:0] REGION_APB = 4'h1;

    // One-hot slave select: bit0 = S0 memory, bit1 = S1 APB bridge
    localparam logic [1:0] SLV_NONE = 2'b00;
    localparam logic [1:0] SLV_MEM  = 2'b01;
    localparam logic [1:0] SLV_APB  = 2'b10;

    // Write response codes
    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    // Map an address region to the one-hot slave select; unmapped -> none
    function automatic logic [1:0] region_to_slv(input logic [3:0] region);
        logic [1:0] slv;
        case (region)
            REGION_MEM: slv = SLV_MEM;
            REGION_APB: slv = SLV_APB;
            default:    slv = SLV_NONE;
        endcase
        return slv;
    endfunction

endpackage

// File: rtl/axi3_wr_arbiter_rr_arb2.sv
// Two-request round-robin picker. On contention the master that did not
// win last time is chosen; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] winner
);

    // Pick a one-hot winner from the current requests
    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last_grant ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi3_wr_arbiter.sv
// AXI3 write-channel arbiter for two masters and two slaves. Grants one
// write burst at a time, routes it by AWADDR[31:28], counts W beats to
// find the burst end, flags WLAST/beat-count mismatches, and answers
// unmapped addresses itself with a DECERR response.
module axi3_wr_arbiter
    import axi3_ic_pkg::*;
(
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic [1:0] m_awvalid,
    input  logic [3:0] m0_awaddr_hi,
    input  logic [3:0] m1_awaddr_hi,
    input  logic [3:0] m0_awlen,
    input  logic [3:0] m1_awlen,
    input  logic       aw_hs,
    input  logic       w_hs,
    input  logic       w_last,
    input  logic       b_hs,
    output logic [1:0] grant,
    output logic [1:0] slv_sel,
    output logic       derr_awready,
    output logic       derr_wready,
    output logic       derr_bvalid,
    output logic [1:0] derr_bresp,
    output logic       wlast_err
);

    arb_state_e state_r;
    arb_state_e state_s;
    logic [1:0] grant_r;
    logic [1:0] grant_s;
    logic [1:0] slv_sel_r;
    logic [1:0] slv_sel_s;
    logic [3:0] count_r;
    logic [3:0] count_s;
    logic       last_grant_r;
    logic       last_grant_s;
    logic       wlast_err_r;
    logic       wlast_err_s;
    logic       derr_awready_r;
    logic       derr_wready_r;
    logic       derr_bvalid_r;

    logic [1:0] winner_s;
    logic [3:0] win_region_s;
    logic [3:0] win_len_s;
    logic [1:0] win_slv_s;
    logic       last_beat_s;

    rr_arb2 u_rr_arb2 (
        .req        (m_awvalid),
        .last_grant (last_grant_r),
        .winner     (winner_s)
    );

    // Route the winning master's region and burst length
    always_comb begin
        if (winner_s[1]) begin
            win_region_s = m1_awaddr_hi;
            win_len_s    = m1_awlen;
        end else begin
            win_region_s = m0_awaddr_hi;
            win_len_s    = m0_awlen;
        end
        win_slv_s   = region_to_slv(win_region_s);
        last_beat_s = (count_r == 4'd0);
    end

    // Next-state, grant and beat-count decisions for the current burst
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        slv_sel_s    = slv_sel_r;
        count_s      = count_r;
        last_grant_s = last_grant_r;
        wlast_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (winner_s != 2'b00) begin
                    grant_s      = winner_s;
                    last_grant_s = winner_s[1];
                    count_s      = win_len_s;
                    slv_sel_s    = win_slv_s;
                    if (win_slv_s == SLV_NONE) begin
                        state_s = ST_DERR_ADDR;
                    end else begin
                        state_s = ST_ADDR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (aw_hs) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DERR_ADDR: begin
                // The error responder accepts the address in a single cycle
                state_s = ST_DERR_DATA;
            end
            ST_DATA, ST_DERR_DATA: begin
                if (w_hs) begin
                    // Burst end follows the count; WLAST is only cross-checked
                    wlast_err_s = (w_last != last_beat_s);
                    if (last_beat_s) begin
                        if (state_r == ST_DATA) begin
                            state_s = ST_RESP;
                        end else begin
                            state_s = ST_DERR_RESP;
                        end
                    end else begin
                        count_s = count_r - 4'd1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_RESP, ST_DERR_RESP: begin
                if (b_hs) begin
                    state_s   = ST_IDLE;
                    grant_s   = 2'b00;
                    slv_sel_s = SLV_NONE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                // Unused encoding: drop any burst and return to a safe idle
                state_s   = ST_IDLE;
                grant_s   = 2'b00;
                slv_sel_s = SLV_NONE;
                count_s   = 4'd0;
            end
        endcase
    end

    // State, routing and registered output update with async reset
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r        <= ST_IDLE;
            grant_r        <= 2'b00;
            slv_sel_r      <= SLV_NONE;
            count_r        <= 4'd0;
            last_grant_r   <= 1'b1;
            wlast_err_r    <= 1'b0;
            derr_awready_r <= 1'b0;
            derr_wready_r  <= 1'b0;
            derr_bvalid_r  <= 1'b0;
        end else begin
            state_r        <= state_s;
            grant_r        <= grant_s;
            slv_sel_r      <= slv_sel_s;
            count_r        <= count_s;
            last_grant_r   <= last_grant_s;
            wlast_err_r    <= wlast_err_s;
            derr_awready_r <= (state_s == ST_DERR_ADDR);
            derr_wready_r  <= (state_s == ST_DERR_DATA);
            derr_bvalid_r  <= (state_s == ST_DERR_RESP);
        end
    end

    assign grant        = grant_r;
    assign slv_sel      = slv_sel_r;
    assign derr_awready = derr_awready_r;
    assign derr_wready  = derr_wready_r;
    assign derr_bvalid  = derr_bvalid_r;
    assign derr_bresp   = BRESP_DECERR;
    assign wlast_err    = wlast_err_r;

endmodule

// File: tb/tb_axi3_wr_arbiter.sv
// Bench for axi3_wr_arbiter: directed scenarios followed by randomized
// traffic, all checked every cycle against a transaction-level model.
module tb_axi3_wr_arbiter;

    logic       ACLK;
    logic       ARESETn;
    logic [1:0] m_awvalid;
    logic [3:0] m0_awaddr_hi;
    logic [3:0] m1_awaddr_hi;
    logic [3:0] m0_awlen;
    logic [3:0] m1_awlen;
    logic       aw_hs;
    logic       w_hs;
    logic       w_last;
    logic       b_hs;
    logic [1:0] grant;
    logic [1:0] slv_sel;
    logic       derr_awready;
    logic       derr_wready;
    logic       derr_bvalid;
    logic [1:0] derr_bresp;
    logic       wlast_err;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: phase of the burst plus bookkeeping
    localparam int P_IDLE = 0;
    localparam int P_ADDR = 1;
    localparam int P_DATA = 2;
    localparam int P_RESP = 3;

    int         ph;
    bit         derr;
    logic [1:0] e_grant;
    logic [1:0] e_slv;
    int         beats_left;
    bit         e_wle;
    int         lg;
    int         just_granted;
    logic [1:0] req;

    axi3_wr_arbiter dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .m_awvalid    (m_awvalid),
        .m0_awaddr_hi (m0_awaddr_hi),
        .m1_awaddr_hi (m1_awaddr_hi),
        .m0_awlen     (m0_awlen),
        .m1_awlen     (m1_awlen),
        .aw_hs        (aw_hs),
        .w_hs         (w_hs),
        .w_last       (w_last),
        .b_hs         (b_hs),
        .grant        (grant),
        .slv_sel      (slv_sel),
        .derr_awready (derr_awready),
        .derr_wready  (derr_wready),
        .derr_bvalid  (derr_bvalid),
        .derr_bresp   (derr_bresp),
        .wlast_err    (wlast_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph           = P_IDLE;
        derr         = 1'b0;
        e_grant      = 2'b00;
        e_slv        = 2'b00;
        beats_left   = 0;
        e_wle        = 1'b0;
        lg           = 1;
        just_granted = -1;
    endtask

    // Advance the model by one clock using the inputs seen at this edge
    task automatic model_step();
        int w;
        logic [3:0] hi;
        e_wle        = 1'b0;
        just_granted = -1;
        case (ph)
            P_IDLE: begin
                if (m_awvalid != 2'b00) begin
                    if (m_awvalid == 2'b11) w = 1 - lg;
                    else w = m_awvalid[1] ? 1 : 0;
                    lg           = w;
                    just_granted = w;
                    e_grant      = (w == 0) ? 2'b01 : 2'b10;
                    beats_left   = ((w == 0) ? int'(m0_awlen) : int'(m1_awlen)) + 1;
                    hi           = (w == 0) ? m0_awaddr_hi : m1_awaddr_hi;
                    if (hi == 4'h0) begin
                        e_slv = 2'b01; derr = 1'b0;
                    end else if (hi == 4'h1) begin
                        e_slv = 2'b10; derr = 1'b0;
                    end else begin
                        e_slv = 2'b00; derr = 1'b1;
                    end
                    ph = P_ADDR;
                end
            end
            P_ADDR: if (derr || aw_hs) ph = P_DATA;
            P_DATA: begin
                if (w_hs) begin
                    e_wle = (w_last != (beats_left == 1));
                    if (beats_left == 1) ph = P_RESP;
                    else beats_left = beats_left - 1;
                end
            end
            P_RESP: begin
                if (b_hs) begin
                    ph = P_IDLE; e_grant = 2'b00; e_slv = 2'b00;
                end
            end
            default: ph = P_IDLE;
        endcase
    endtask

    // One clock: update the model, then the granted master drops AWVALID
    task automatic cyc();
        @(posedge ACLK);
        if (ARESETn) model_step();
        #1;
        if (just_granted >= 0) req[just_granted] = 1'b0;
        m_awvalid = req;
    endtask

    task automatic apply();
        m_awvalid = req;
    endtask

    task automatic do_aw();
        aw_hs = 1'b1; cyc(); aw_hs = 1'b0;
    endtask

    task automatic do_beat(input bit last);
        w_hs = 1'b1; w_last = last; cyc(); w_hs = 1'b0; w_last = 1'b0;
    endtask

    task automatic do_resp();
        b_hs = 1'b1; cyc(); b_hs = 1'b0;
    endtask

    task automatic zero_inputs();
        req = 2'b00; m_awvalid = 2'b00;
        aw_hs = 1'b0; w_hs = 1'b0; w_last = 1'b0; b_hs = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        ARESETn = 1'b0;
        model_reset();
        zero_inputs();
        cyc();
        cyc();
        #1 ARESETn = 1'b1;
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge ACLK) begin
        chk("grant", grant, e_grant);
        chk("slv_sel", slv_sel, e_slv);
        chk("derr_awready", derr_awready, derr && ph == P_ADDR);
        chk("derr_wready", derr_wready, derr && ph == P_DATA);
        chk("derr_bvalid", derr_bvalid, derr && ph == P_RESP);
        chk("derr_bresp", derr_bresp, 2'b11);
        chk("wlast_err", wlast_err, e_wle);
    end

    initial begin
        ARESETn = 1'b0;
        model_reset();
        zero_inputs();
        m0_awaddr_hi = 4'h0; m1_awaddr_hi = 4'h0; m0_awlen = 4'h0; m1_awlen = 4'h0;
        cyc(); cyc();
        chk("rst_grant", grant, 2'b00);
        chk("rst_slv_sel", slv_sel, 2'b00);
        #1 ARESETn = 1'b1;

        // Both masters at 0x0, single beat: M0 first, M1 after b_hs + idle
        req = 2'b11; apply();
        cyc();
        chk("tie_grant_m0", grant, 2'b01);
        chk("tie_slv_mem", slv_sel, 2'b01);
        do_aw(); do_beat(1'b1);
        chk("single_beat_wle", wlast_err, 1'b0);
        do_resp();
        chk("idle_gap_grant", grant, 2'b00);
        cyc();
        chk("second_grant_m1", grant, 2'b10);
        do_aw(); do_beat(1'b1); do_resp();

        // M1 alone to APB region, AWLEN=3; early b_hs must be ignored
        m1_awaddr_hi = 4'h1; m1_awlen = 4'd3; req = 2'b10; apply();
        cyc();
        chk("apb_grant", grant, 2'b10);
        chk("apb_slv_sel", slv_sel, 2'b10);
        do_aw();
        for (int i = 0; i < 3; i++) begin
            do_beat(1'b0);
            chk("apb_beat_wle", wlast_err, 1'b0);
        end
        do_resp();
        chk("apb_hold_before_last", grant, 2'b10);
        do_beat(1'b1);
        chk("apb_last_wle", wlast_err, 1'b0);
        chk("apb_model_resp", ph, P_RESP);
        do_resp();
        chk("apb_release", grant, 2'b00);

        // M0 to unmapped region, AWLEN=1: decode-error path
        m0_awaddr_hi = 4'h2; m0_awlen = 4'd1; req = 2'b01; apply();
        cyc();
        chk("derr_grant", grant, 2'b01);
        chk("derr_slv_none", slv_sel, 2'b00);
        chk("derr_aw_pulse", derr_awready, 1'b1);
        cyc();
        chk("derr_aw_done", derr_awready, 1'b0);
        chk("derr_w_on", derr_wready, 1'b1);
        do_beat(1'b0);
        chk("derr_w_beat1", derr_wready, 1'b1);
        do_beat(1'b1);
        chk("derr_w_off", derr_wready, 1'b0);
        chk("derr_b_on", derr_bvalid, 1'b1);
        chk("derr_bresp_val", derr_bresp, 2'b11);
        cyc();
        chk("derr_b_hold", derr_bvalid, 1'b1);
        do_resp();
        chk("derr_b_off", derr_bvalid, 1'b0);
        chk("derr_release", grant, 2'b00);

        // AWLEN=2 with early WLAST on beat 2
        m1_awaddr_hi = 4'h0; m1_awlen = 4'd2; req = 2'b10; apply();
        cyc(); do_aw();
        do_beat(1'b0);
        chk("early_last_b1", wlast_err, 1'b0);
        do_beat(1'b1);
        chk("early_last_pulse", wlast_err, 1'b1);
        do_resp();
        chk("early_last_no_resp", grant, 2'b10);
        do_beat(1'b1);
        chk("early_last_b3", wlast_err, 1'b0);
        do_resp();
        chk("early_last_release", grant, 2'b00);

        // Reset during beat 2 of an AWLEN=7 burst from M0
        m0_awaddr_hi = 4'h0; m0_awlen = 4'd7; req = 2'b01; apply();
        cyc(); do_aw(); do_beat(1'b0);
        w_hs = 1'b1; w_last = 1'b0;
        #2 ARESETn = 1'b0;
        model_reset(); zero_inputs();
        #1;
        chk("mid_reset_grant", grant, 2'b00);
        cyc();
        #1 ARESETn = 1'b1;
        req = 2'b11; apply();
        cyc();
        chk("post_reset_grant_m0", grant, 2'b01);

        // Randomized traffic driven from the model's view of the burst
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] && ($urandom % 4 == 0)) begin
                    logic [3:0] hi_v;
                    logic [3:0] len_v;
                    case ($urandom % 5)
                        0, 1:    hi_v = 4'h0;
                        2, 3:    hi_v = 4'h1;
                        default: hi_v = 4'($urandom_range(2, 15));
                    endcase
                    len_v = ($urandom % 3 == 0) ? 4'($urandom % 16) : 4'($urandom % 3);
                    if (i == 0) begin
                        m0_awaddr_hi = hi_v; m0_awlen = len_v;
                    end else begin
                        m1_awaddr_hi = hi_v; m1_awlen = len_v;
                    end
                    req[i] = 1'b1;
                end
            end
            aw_hs  = (ph == P_ADDR && !derr) ? ($urandom % 2 == 0) : ($urandom % 8 == 0);
            w_hs   = (ph == P_DATA) ? ($urandom % 3 != 0) : ($urandom % 10 == 0);
            w_last = w_hs ? ((beats_left == 1) ^ ($urandom % 6 == 0)) : ($urandom % 2 == 0);
            b_hs   = (ph == P_RESP) ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
            apply();
            if ($urandom % 600 == 0) do_reset();
            cyc();
        end

        zero_inputs();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
